cla_pipe_adder: RTL

//  Parametrised, two-stage pipelined carry-lookahead adder/subtractor for

---
 rtl/cla_pipe_adder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 captures per-bit and per-group propagate/generate; stage 2 resolves carries.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NG = WIDTH / GROUP;

  // operand conditioning and stage-1 terms
  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH-1:0] p_c;
  logic [WIDTH-1:0] g_c;
  logic             c0_c;
  logic [NG-1:0]    gp_c;
  logic [NG-1:0]    gg_c;
  logic             gterm_c;

  // stage-1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [NG-1:0]    gp_q, gp_d;
  logic [NG-1:0]    gg_q, gg_d;
  logic             c0_q, c0_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  // stage-2 carry resolution
  logic [NG:0]      grp_c;
  logic             cacc_c;
  logic             cterm_c;
  logic [WIDTH-1:0] bc_c;
  logic             bacc_c;
  logic             bterm_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;
  logic             adv2_c;

  // output registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  assign b_eff_c = sub ? ~b : b;
  assign c0_c    = sub | cin;
  assign p_c     = a ^ b_eff_c;
  assign g_c     = a & b_eff_c;

  // Group propagate/generate as a flat sum of products over each group.
  always_comb begin
    gp_c    = '0;
    gg_c    = '0;
    gterm_c = 1'b0;
    for (int unsigned k = 0; k < NG; k++) begin
      gp_c[k] = &p_c[k*GROUP +: GROUP];
      for (int unsigned j = 0; j < GROUP; j++) begin
        gterm_c = g_c[k*GROUP + j];
        for (int unsigned m = j + 1; m < GROUP; m++) begin
          gterm_c = gterm_c & p_c[k*GROUP + m];
        end
        gg_c[k] = gg_c[k] | gterm_c;
      end
    end
  end

  // Group carries: each C[k+1] is a two-level expansion down to c0, no ripple between groups.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = c0_q;
    cacc_c   = 1'b0;
    cterm_c  = 1'b0;
    for (int unsigned k = 0; k < NG; k++) begin
      cacc_c = 1'b0;
      for (int unsigned j = 0; j <= k; j++) begin
        cterm_c = gg_q[j];
        for (int unsigned m = j + 1; m <= k; m++) begin
          cterm_c = cterm_c & gp_q[m];
        end
        cacc_c = cacc_c | cterm_c;
      end
      cterm_c = c0_q;
      for (int unsigned m = 0; m <= k; m++) begin
        cterm_c = cterm_c & gp_q[m];
      end
      grp_c[k+1] = cacc_c | cterm_c;
    end
  end

  // Intra-group bit carries, expanded from the group's incoming carry.
  always_comb begin
    bc_c    = '0;
    bacc_c  = 1'b0;
    bterm_c = 1'b0;
    for (int unsigned k = 0; k < NG; k++) begin
      for (int unsigned i = 0; i < GROUP; i++) begin
        bacc_c = 1'b0;
        for (int unsigned j = 0; j < i; j++) begin
          bterm_c = g_q[k*GROUP + j];
          for (int unsigned m = j + 1; m < i; m++) begin
            bterm_c = bterm_c & p_q[k*GROUP + m];
          end
          bacc_c = bacc_c | bterm_c;
        end
        bterm_c = grp_c[k];
        for (int unsigned m = 0; m < i; m++) begin
          bterm_c = bterm_c & p_q[k*GROUP + m];
        end
        bc_c[k*GROUP + i] = bacc_c | bterm_c;
      end
    end
  end

  assign sum_c  = p_q ^ bc_c;
  assign cout_c = grp_c[NG];
  assign ovf_c  = (a_msb_q == b_msb_q) & (sum_c[WIDTH-1] != a_msb_q);

  assign adv2_c   = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = rst_n & (~s1_valid_q | adv2_c);

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    p_d         = p_q;
    g_d         = g_q;
    gp_d        = gp_q;
    gg_d        = gg_q;
    c0_d        = c0_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        p_d     = p_c;
        g_d     = g_c;
        gp_d    = gp_c;
        gg_d    = gg_c;
        c0_d    = c0_c;
        a_msb_d = a[WIDTH-1];
        b_msb_d = b_eff_c[WIDTH-1];
      end
    end
    if (adv2_c) begin
      out_valid_d = 1'b1;
      sum_d       = sum_c;
      cout_d      = cout_c;
      ovf_d       = ovf_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      p_q         <= '0;
      g_q         <= '0;
      gp_q        <= '0;
      gg_q        <= '0;
      c0_q        <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      p_q         <= p_d;
      g_q         <= g_d;
      gp_q        <= gp_d;
      gg_q        <= gg_d;
      c0_q        <= c0_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
